// File: rtl/hazard_scoreboard.sv
// Issue-stage interlock: per-register forwarding countdowns, single-divider
// serialisation and a saturating stall-cycle counter.
module hazard_scoreboard #(
   parameter int NREG     = 32,
   parameter int LOAD_LAT = 1,
   parameter int MUL_LAT  = 2,
   parameter int CNT_W    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic        id_rs1_ren,
   input  logic [4:0]  id_rs1,
   input  logic        id_rs2_ren,
   input  logic [4:0]  id_rs2,
   input  logic        id_rd_we,
   input  logic [4:0]  id_rd,
   input  logic [1:0]  id_op_class,
   input  logic        ex_allowin,
   input  logic        pipe_adv,
   input  logic        div_done,
   input  logic        flush,
   output logic        id_stall,
   output logic        id_fire,
   output logic        div_busy,
   output logic        div_kill,
   output logic [31:0] stall_cnt
);
   localparam logic [1:0] OP_ALU  = 2'd0;
   localparam logic [1:0] OP_LOAD = 2'd1;
   localparam logic [1:0] OP_MUL  = 2'd2;
   localparam logic [1:0] OP_DIV  = 2'd3;

   logic [NREG-1:0][CNT_W-1:0] cnt;
   logic [4:0]                 div_rd;
   logic [CNT_W-1:0]           issue_val;
   logic rs1_hz, rs2_hz, waw_hz, div_struct, wr_issue;

   // A source is blocked while its countdown runs or the divider owns it.
   assign rs1_hz = id_rs1_ren && (id_rs1 != 5'd0) &&
                   ((cnt[id_rs1] != '0) || (div_busy && (div_rd == id_rs1)));
   assign rs2_hz = id_rs2_ren && (id_rs2 != 5'd0) &&
                   ((cnt[id_rs2] != '0) || (div_busy && (div_rd == id_rs2)));
   assign waw_hz     = id_rd_we && (id_rd != 5'd0) && div_busy && (div_rd == id_rd);
   assign div_struct = (id_op_class == OP_DIV) && div_busy;

   assign id_stall = id_valid && (rs1_hz || rs2_hz || waw_hz || div_struct);
   assign id_fire  = id_valid && ex_allowin && !id_stall && !flush;
   assign div_kill = flush && div_busy;
   assign wr_issue = id_fire && id_rd_we && (id_rd != 5'd0);

   always_comb begin
      issue_val = '0;
      case (id_op_class)
         OP_LOAD: issue_val = CNT_W'(LOAD_LAT);
         OP_MUL:  issue_val = CNT_W'(MUL_LAT);
         default: issue_val = '0;
      endcase
   end

   // Issue overrides the decrement of the same entry; r0 stays zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (flush || r == 0)
               cnt[r] <= '0;
            else if (wr_issue && (id_rd == 5'(r)) && (id_op_class != OP_DIV))
               cnt[r] <= issue_val;
            else if (pipe_adv && (cnt[r] != '0))
               cnt[r] <= cnt[r] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_busy <= 1'b0;
         div_rd   <= 5'd0;
      end else if (flush) begin
         div_busy <= 1'b0;
      end else if (wr_issue && (id_op_class == OP_DIV)) begin
         div_busy <= 1'b1;
         div_rd   <= id_rd;
      end else if (div_done) begin
         div_busy <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (id_stall && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 32'd1;
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scenarios plus randomized traffic against a per-register
// cycles-remaining model of the scoreboard.
module tb_hazard_scoreboard;
   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_rs1_ren, id_rs2_ren, id_rd_we;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [1:0]  id_op_class;
   logic        ex_allowin, pipe_adv, div_done, flush;
   logic        id_stall, id_fire, div_busy, div_kill;
   logic [31:0] stall_cnt;

   int          checks = 0;
   int          errors = 0;

   // Reference model: cycles until each register is forwardable.
   int          rem[32];
   bit          mbusy;
   int          mrd;
   logic [31:0] mstall;

   hazard_scoreboard dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1_ren(id_rs1_ren), .id_rs1(id_rs1),
      .id_rs2_ren(id_rs2_ren), .id_rs2(id_rs2), .id_rd_we(id_rd_we), .id_rd(id_rd),
      .id_op_class(id_op_class), .ex_allowin(ex_allowin), .pipe_adv(pipe_adv),
      .div_done(div_done), .flush(flush), .id_stall(id_stall), .id_fire(id_fire),
      .div_busy(div_busy), .div_kill(div_kill), .stall_cnt(stall_cnt));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_hz(input bit ren, input int s);
      return ren && s != 0 && (rem[s] != 0 || (mbusy && mrd == s));
   endfunction

   task automatic set_id(input bit v, input bit r1en, input int r1, input bit r2en, input int r2,
                         input bit we, input int rd, input int op);
      id_valid = v; id_rs1_ren = r1en; id_rs1 = 5'(r1); id_rs2_ren = r2en; id_rs2 = 5'(r2);
      id_rd_we = we; id_rd = 5'(rd); id_op_class = 2'(op);
   endtask

   task automatic set_ctl(input bit allow, input bit adv, input bit done, input bit fl);
      ex_allowin = allow; pipe_adv = adv; div_done = done; flush = fl;
   endtask

   task automatic model_clear();
      foreach (rem[i]) rem[i] = 0;
      mbusy = 0; mrd = 0; mstall = '0;
   endtask

   // Check outputs mid-cycle against the model, then advance model over the edge.
   task automatic tick(input int exp_st = -1, input int exp_kill = -1);
      bit e_stall, e_fire, e_kill, dissue;
      int rd;
      #4;
      rd = int'(id_rd);
      e_stall = id_valid && (m_hz(id_rs1_ren, int'(id_rs1)) || m_hz(id_rs2_ren, int'(id_rs2)) ||
                (id_rd_we && rd != 0 && mbusy && mrd == rd) || (id_op_class == 2'd3 && mbusy));
      e_fire  = id_valid && ex_allowin && !e_stall && !flush;
      e_kill  = flush && mbusy;
      chk("id_stall", 32'(id_stall), 32'(e_stall));
      chk("id_fire", 32'(id_fire), 32'(e_fire));
      chk("div_kill", 32'(div_kill), 32'(e_kill));
      chk("div_busy", 32'(div_busy), 32'(mbusy));
      chk("stall_cnt", stall_cnt, mstall);
      if (exp_st >= 0) chk("dir_stall", 32'(id_stall), 32'(exp_st));
      if (exp_kill >= 0) chk("dir_kill", 32'(div_kill), 32'(exp_kill));
      @(posedge clk);
      if (e_stall && mstall != 32'hFFFF_FFFF) mstall++;
      if (flush) begin
         foreach (rem[i]) rem[i] = 0;
         mbusy = 0;
      end else begin
         if (pipe_adv) foreach (rem[i]) if (rem[i] > 0) rem[i]--;
         dissue = 0;
         if (e_fire && id_rd_we && rd != 0) begin
            case (int'(id_op_class))
               0: rem[rd] = 0;
               1: rem[rd] = 1;
               2: rem[rd] = 2;
               default: begin dissue = 1; mbusy = 1; mrd = rd; end
            endcase
         end
         if (!dissue && div_done) mbusy = 0;
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      set_ctl(1, 1, 0, 0);
      #1;
      model_clear();
      chk("rst_stall", 32'(id_stall), 32'd0);
      chk("rst_fire", 32'(id_fire), 32'd0);
      chk("rst_busy", 32'(div_busy), 32'd0);
      chk("rst_kill", 32'(div_kill), 32'd0);
      chk("rst_stall_cnt", stall_cnt, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      do_reset();

      // 1: load-use costs one stall cycle
      set_id(1, 0, 0, 0, 0, 1, 5, 1); tick(0);
      set_id(1, 1, 5, 0, 0, 1, 8, 0); tick(1);
      tick(0);
      chk("t1_stall_cnt", stall_cnt, 32'd1);

      // 2: MUL with three frozen back-end cycles
      do_reset();
      set_id(1, 0, 0, 0, 0, 1, 7, 2); tick(0);
      set_id(1, 1, 7, 1, 0, 1, 9, 0);
      set_ctl(1, 0, 0, 0);
      repeat (3) tick(1);
      set_ctl(1, 1, 0, 0);
      tick(1); tick(1); tick(0);
      chk("t2_stall_cnt", stall_cnt, 32'd5);

      // 3: divider WAW and structural hazards released the cycle after div_done
      do_reset();
      set_id(1, 0, 0, 0, 0, 1, 3, 3); tick(0);
      set_id(1, 0, 0, 0, 0, 1, 3, 0); tick(1);
      set_id(1, 0, 0, 0, 0, 1, 4, 3); tick(1);
      set_id(1, 0, 0, 0, 0, 1, 3, 0); set_ctl(1, 1, 1, 0); tick(1);
      set_ctl(1, 1, 0, 0); tick(0);
      chk("t3_busy", 32'(div_busy), 32'd0);
      set_id(1, 0, 0, 0, 0, 1, 4, 3); tick(0);

      // 4: flush kills the divide and clears pending countdowns
      do_reset();
      set_ctl(1, 0, 0, 0);
      set_id(1, 0, 0, 0, 0, 1, 6, 1); tick(0);
      set_id(1, 0, 0, 0, 0, 1, 3, 3); tick(0);
      set_id(0, 0, 0, 0, 0, 0, 0, 0); set_ctl(1, 0, 0, 1); tick(-1, 1);
      chk("t4_busy", 32'(div_busy), 32'd0);
      set_ctl(1, 0, 0, 0);
      set_id(1, 1, 6, 1, 3, 0, 0, 0); tick(0);

      // 5: r0 never hazards; a disabled rs2 is ignored
      do_reset();
      set_id(1, 0, 0, 0, 0, 1, 0, 1); tick(0);
      set_id(1, 1, 0, 1, 0, 0, 0, 0); tick(0);
      set_id(1, 0, 0, 0, 0, 1, 6, 1); tick(0);
      set_ctl(1, 0, 0, 0);
      set_id(1, 1, 0, 0, 6, 0, 0, 0); tick(0); tick(0);

      // 6: asynchronous reset mid-cycle with live state
      do_reset();
      set_ctl(1, 0, 0, 0);
      set_id(1, 0, 0, 0, 0, 1, 9, 2); tick(0);
      set_id(1, 0, 0, 0, 0, 1, 10, 3); tick(0);
      set_id(1, 1, 9, 0, 0, 0, 0, 0);
      #2;
      chk("t6_pre_stall", 32'(id_stall), 32'd1);
      chk("t6_pre_busy", 32'(div_busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("t6_stall", 32'(id_stall), 32'd0);
      chk("t6_busy", 32'(div_busy), 32'd0);
      chk("t6_stall_cnt", stall_cnt, 32'd0);
      @(posedge clk); #1;
      do_reset();

      // Randomized traffic over a small register window to provoke hazards
      for (int n = 0; n < 600; n++) begin
         set_id($urandom_range(99) < 80, $urandom_range(1), $urandom_range(7),
                $urandom_range(1), $urandom_range(7), $urandom_range(1),
                $urandom_range(7), $urandom_range(3));
         set_ctl($urandom_range(99) < 80, $urandom_range(99) < 70,
                 mbusy ? ($urandom_range(99) < 15) : ($urandom_range(99) < 3),
                 $urandom_range(99) < 4);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
